// File: rtl/tc_wq_pkg.sv
// Shared types and helpers for the register write-back queue.
// Default localparams describe the nominal bank (8 x 8-bit registers,
// 3-bit address, 4-entry queue); the modules override them via parameters.
package tc_wq_pkg;

  localparam int WQ_DATA_W     = 8;
  localparam int WQ_ADDR_W     = 3;
  localparam int WQ_NUM_REGS   = 8;
  localparam int WQ_DEPTH      = 4;

  // Upper bounds for the generic one-hot decoder.
  localparam int WQ_MAX_REGS   = 64;
  localparam int WQ_MAX_ADDR_W = 16;

  // Queue entry layout for the default bank.
  typedef struct packed {
    logic [WQ_ADDR_W-1:0] addr;
    logic [WQ_DATA_W-1:0] data;
  } wq_entry_t;

  // One-hot decode of addr; an address outside the bank decodes to all zeros
  // so the write is silently dropped.
  function automatic logic [WQ_MAX_REGS-1:0] onehot_dec(
    input logic [WQ_MAX_ADDR_W-1:0] addr,
    input int unsigned              num_regs
  );
    if (32'(addr) < num_regs) return WQ_MAX_REGS'(1) << addr;
    return '0;
  endfunction

endpackage

// File: rtl/tc_wq_fifo.sv
// Generic synchronous FIFO with flush and full visibility of its storage.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   push, pop     - enqueue wdata / dequeue head (ignored when full / empty)
//   flush         - synchronous clear, overrides push and pop
//   wdata, rdata  - tail write data, current head data
//   count         - number of valid entries; full / empty derived from it
//   entries/valid - raw storage and per-slot valid bits
module tc_wq_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic [CNT_W-1:0]            count,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0][WIDTH-1:0] entries,
  output logic [DEPTH-1:0]            valid
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic                        do_push;
  logic                        do_pop;
  logic [PTR_W-1:0]            offset;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign entries = mem;

  // A slot is live when its distance from the head is below count.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = PTR_W'(i) - rd_ptr;
      valid[i] = CNT_W'(offset) < count;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tc_reg_write_queue.sv
// Write-back queue feeding a bank of registers: buffers write requests in
// order and retires one per cycle as a one-hot save strobe plus data bus.
// Ports:
//   clk, rst                       - clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data - write request handshake
//   flush                          - discard all queued entries
//   hold                           - bank cannot accept a write this cycle
//   save, reg_in                   - one-hot strobes and data to the bank
//   query_addr, query_pending      - hazard check against queued writes
//   count                          - number of queued entries
module tc_reg_write_queue
  import tc_wq_pkg::*;
#(
  parameter int BIT_WIDTH  = WQ_DATA_W,
  parameter int NUM_REGS   = WQ_NUM_REGS,
  parameter int ADDR_WIDTH = WQ_ADDR_W,
  parameter int DEPTH      = WQ_DEPTH,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BIT_WIDTH-1:0]  wr_data,
  input  logic                  flush,
  input  logic                  hold,
  output logic [NUM_REGS-1:0]   save,
  output logic [BIT_WIDTH-1:0]  reg_in,
  input  logic [ADDR_WIDTH-1:0] query_addr,
  output logic                  query_pending,
  output logic [CNT_W-1:0]      count
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [BIT_WIDTH-1:0]  data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t                   head;
  entry_t                   tail_in;
  entry_t                   slot;
  logic [DEPTH-1:0][EW-1:0] entries;
  logic [DEPTH-1:0]         valid;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;

  // Gating with rst keeps ready low while the queue is held in reset.
  assign wr_ready = rst && !full;
  assign push     = wr_valid && wr_ready;
  assign pop      = !empty && !hold;
  assign tail_in  = '{addr: wr_addr, data: wr_data};

  tc_wq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (tail_in),
    .rdata   (head),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .entries (entries),
    .valid   (valid)
  );

  // Out-of-range addresses decode to zero: the entry still retires.
  always_comb begin
    save   = '0;
    reg_in = '0;
    if (pop) begin
      save   = NUM_REGS'(onehot_dec(WQ_MAX_ADDR_W'(head.addr), 32'(NUM_REGS)));
      reg_in = head.data;
    end
  end

  always_comb begin
    query_pending = 1'b0;
    slot          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = entries[i];
      if (valid[i] && (slot.addr == query_addr)) query_pending = 1'b1;
    end
  end

endmodule

// File: tb/tb_tc_reg_write_queue.sv
module tb_tc_reg_write_queue;

  localparam int BW = 8;
  localparam int NR = 8;
  localparam int AW = 4;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [BW-1:0] wr_data = '0;
  logic          flush = 1'b0;
  logic          hold = 1'b0;
  logic [NR-1:0] save;
  logic [BW-1:0] reg_in;
  logic [AW-1:0] query_addr = '0;
  logic          query_pending;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  tc_reg_write_queue #(
    .BIT_WIDTH  (BW),
    .NUM_REGS   (NR),
    .ADDR_WIDTH (AW),
    .DEPTH      (DP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .flush         (flush),
    .hold          (hold),
    .save          (save),
    .reg_in        (reg_in),
    .query_addr    (query_addr),
    .query_pending (query_pending),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are changed and outputs sampled here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [BW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_save", 32'(save), 0);
    check("rst_reg_in", 32'(reg_in), 0);
    check("rst_ready", 32'(wr_ready), 0);
    check("rst_pending", 32'(query_pending), 0);
    cyc(); cyc();
    rst = 1'b1;
    #1;
    check("ready_after_rst", 32'(wr_ready), 1);

    // single write, latency
    push(4'd3, 8'h5A);
    check("t1_save", 32'(save), 32'h08);
    check("t1_reg_in", 32'(reg_in), 32'h5A);
    check("t1_count", 32'(count), 1);
    cyc();
    check("t1_save_after", 32'(save), 0);
    check("t1_count_after", 32'(count), 0);

    // fill under hold
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(AW'(i), BW'(8'h10 + i));
    check("t2_count", 32'(count), 4);
    check("t2_ready", 32'(wr_ready), 0);
    check("t2_save", 32'(save), 0);

    // drain while offering another write
    wr_valid = 1'b1; wr_addr = 4'd4; wr_data = 8'h44;
    hold = 1'b0;
    #1;
    check("t3_save0", 32'(save), 32'h01);
    check("t3_reg0", 32'(reg_in), 32'h10);
    check("t3_ready_full", 32'(wr_ready), 0);
    cyc();
    check("t3_count_a", 32'(count), 3);
    check("t3_ready_up", 32'(wr_ready), 1);
    check("t3_save1", 32'(save), 32'h02);
    cyc();
    wr_valid = 1'b0;
    check("t3_count_b", 32'(count), 3);
    check("t3_save2", 32'(save), 32'h04);
    cyc();
    check("t3_save3", 32'(save), 32'h08);
    check("t3_count_c", 32'(count), 2);
    cyc();
    check("t3_save4", 32'(save), 32'h10);
    check("t3_reg4", 32'(reg_in), 32'h44);
    cyc();
    check("t3_empty", 32'(count), 0);
    check("t3_save_idle", 32'(save), 0);

    // hazard query
    hold = 1'b1;
    query_addr = 4'd5;
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 8'h55;
    #1;
    check("t4_pend_same_cycle", 32'(query_pending), 0);
    cyc();
    wr_valid = 1'b0;
    check("t4_pend_hit", 32'(query_pending), 1);
    query_addr = 4'd6;
    #1;
    check("t4_pend_miss", 32'(query_pending), 0);
    hold = 1'b0;
    #1;
    check("t4_save", 32'(save), 32'h20);
    cyc();
    query_addr = 4'd5;
    #1;
    check("t4_pend_retired", 32'(query_pending), 0);

    // out-of-range address is dropped
    push(4'd9, 8'h99);
    check("t5_save", 32'(save), 0);
    check("t5_reg_in", 32'(reg_in), 32'h99);
    check("t5_count", 32'(count), 1);
    cyc();
    check("t5_count_after", 32'(count), 0);

    // flush with concurrent push
    hold = 1'b1;
    push(4'd1, 8'hA1);
    push(4'd2, 8'hA2);
    push(4'd3, 8'hA3);
    check("t6_count", 32'(count), 3);
    flush = 1'b1;
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 8'h77;
    hold = 1'b0;
    #1;
    check("t6_save_flush", 32'(save), 32'h02);
    cyc();
    flush = 1'b0; wr_valid = 1'b0;
    check("t6_count_flushed", 32'(count), 0);
    check("t6_save_after", 32'(save), 0);
    cyc();
    check("t6_save_later", 32'(save), 0);

    // reset mid-drain
    hold = 1'b1;
    push(4'd6, 8'hB6);
    push(4'd7, 8'hB7);
    hold = 1'b0;
    #1;
    check("t7_save_pre", 32'(save), 32'h40);
    rst = 1'b0;
    #1;
    check("t7_save_rst", 32'(save), 0);
    check("t7_count_rst", 32'(count), 0);
    check("t7_ready_rst", 32'(wr_ready), 0);
    cyc();
    rst = 1'b1;
    #1;
    check("t7_ready_rel", 32'(wr_ready), 1);
    check("t7_count_rel", 32'(count), 0);
    push(4'd2, 8'hC2);
    check("t7_push_after", 32'(save), 32'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
